// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with a bounded hold time.
// Each grant ends on done, on abandon, or at MAX_HOLD; at least one idle cycle separates grants.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [2:0] sel_idx;
  logic [2:0] cand;
  logic       hit_limit;
  logic       abandon;

  // First set request bit, scanning upward from ptr with wraparound.
  always_comb begin
    found   = 1'b0;
    sel_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign hit_limit = (cnt_q == HOLD_LIMIT);
  assign abandon   = ~req[grant_idx_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          cnt_d         = 8'd1;
          grant_idx_d   = sel_idx;
          grant_d       = 8'b1 << sel_idx;
          grant_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (done || abandon || hit_limit) begin
          state_d       = IDLE;
          cnt_d         = 8'd0;
          grant_d       = 8'b0;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 3'd1;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d     = hit_limit && !done && !abandon;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 3'd0;
      cnt_q         <= 8'd0;
      grant_q       <= 8'b0;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule
